// File: rtl/mdu_hilo_pkg.sv
// Shared ALU control codes for the multiply/divide unit and its decoder.
// Helpers classify a code as a multiply, a divide or a signed operation.
package mdu_hilo_pkg;

    localparam logic [4:0] MULT_CONTROL  = 5'b10000;
    localparam logic [4:0] MULTU_CONTROL = 5'b10001;
    localparam logic [4:0] DIV_CONTROL   = 5'b10010;
    localparam logic [4:0] DIVU_CONTROL  = 5'b10011;
    localparam logic [4:0] MTHI_CONTROL  = 5'b10100;
    localparam logic [4:0] MTLO_CONTROL  = 5'b10101;

    function automatic logic is_mul_code(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == MULTU_CONTROL);
    endfunction

    function automatic logic is_div_code(input logic [4:0] code);
        return (code == DIV_CONTROL) || (code == DIVU_CONTROL);
    endfunction

    function automatic logic is_signed_code(input logic [4:0] code);
        return (code == MULT_CONTROL) || (code == DIV_CONTROL);
    endfunction

endpackage

// File: rtl/mdu_hilo_div_radix2.sv
// Iterative unsigned restoring divider: one quotient bit per cycle.
// Operands latch on start; abort drops any partial result.
module div_radix2 #(
    parameter int WIDTH = 32,
    parameter int ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             last,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CW = $clog2(ITERS);
    localparam logic [CW-1:0] LAST_CNT = CW'(ITERS - 1);

    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] trial;

    // The partial remainder is below the divisor, so one extra bit holds the shifted value.
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign trial   = shifted[WIDTH-1:0] - dvs_q;

    always_comb begin
        quo_d  = quo_q;
        rem_d  = rem_q;
        dvs_d  = dvs_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        if (abort) begin
            busy_d = 1'b0;
            cnt_d  = '0;
        end else if (start) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvs_d  = divisor;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (shifted >= {1'b0, dvs_q}) begin
                rem_d = trial;
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            if (cnt_q == LAST_CNT) begin
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            quo_q  <= '0;
            rem_q  <= '0;
            dvs_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            quo_q  <= quo_d;
            rem_q  <= rem_d;
            dvs_q  <= dvs_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

    assign busy      = busy_q;
    assign last      = busy_q && (cnt_q == LAST_CNT);
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule

// File: rtl/mdu_hilo.sv
// EX-stage multiply/divide unit owning HI/LO; stalls upstream while busy.
// Divides run on magnitudes in div_radix2 and are sign-corrected in FIX.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int DIV_ITERS = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid,
    input  logic [4:0]       aluctrl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
    logic [WIDTH-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
    logic             sgn_q, sgn_d;
    logic             quo_neg_q, quo_neg_d, rem_neg_q, rem_neg_d;

    logic             accept, signed_op, div_start;
    logic             div_busy, div_last;
    logic [WIDTH-1:0] abs_a, abs_b, div_quo, div_rem;
    logic [2*WIDTH-1:0] ext_a, ext_b, product;

    assign accept    = valid && (state_q == S_IDLE) && !flush;
    assign signed_op = is_signed_code(aluctrl);
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;

    // Extending both operands to 2*WIDTH makes one truncated multiply serve MULT and MULTU.
    assign ext_a   = sgn_q ? {{WIDTH{op_a_q[WIDTH-1]}}, op_a_q} : {{WIDTH{1'b0}}, op_a_q};
    assign ext_b   = sgn_q ? {{WIDTH{op_b_q[WIDTH-1]}}, op_b_q} : {{WIDTH{1'b0}}, op_b_q};
    assign product = ext_a * ext_b;

    assign div_start = accept && is_div_code(aluctrl);

    div_radix2 #(.WIDTH(WIDTH), .ITERS(DIV_ITERS)) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .abort    (flush),
        .dividend (abs_a),
        .divisor  (abs_b),
        .busy     (div_busy),
        .last     (div_last),
        .quotient (div_quo),
        .remainder(div_rem)
    );

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        op_a_d    = op_a_q;
        op_b_d    = op_b_q;
        sgn_d     = sgn_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        stall     = 1'b0;
        done      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (is_mul_code(aluctrl)) begin
                        stall   = 1'b1;
                        state_d = S_MUL;
                        op_a_d  = a;
                        op_b_d  = b;
                        sgn_d   = signed_op;
                    end else if (is_div_code(aluctrl)) begin
                        stall     = 1'b1;
                        state_d   = S_DIV;
                        quo_neg_d = signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg_d = signed_op && a[WIDTH-1];
                    end else if (aluctrl == MTHI_CONTROL) begin
                        hi_d = a;
                    end else if (aluctrl == MTLO_CONTROL) begin
                        lo_d = a;
                    end
                end
            end
            S_MUL: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done         = 1'b1;
                    {hi_d, lo_d} = product;
                end
            end
            S_DIV: begin
                if (flush) begin
                    state_d = S_IDLE;
                end else begin
                    stall = 1'b1;
                    if (div_last) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!flush) begin
                    done = 1'b1;
                    lo_d = quo_neg_q ? -div_quo : div_quo;
                    hi_d = rem_neg_q ? -div_rem : div_rem;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            sgn_q     <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            op_a_q    <= op_a_d;
            op_b_q    <= op_b_d;
            sgn_q     <= sgn_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: multiply, divide, HI/LO moves, flush and reset.
// Inputs change 1ns after the rising edge; outputs are read 1-2ns later.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, valid, flush;
    logic [4:0]   aluctrl;
    logic [W-1:0] a, b, hi, lo;
    logic         stall, done;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mdu_hilo #(.WIDTH(W), .DIV_ITERS(32)) dut (
        .clk    (clk),
        .rst    (rst),
        .valid  (valid),
        .aluctrl(aluctrl),
        .a      (a),
        .b      (b),
        .flush  (flush),
        .stall  (stall),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid   = 1'b0;
        aluctrl = 5'b00000;
        a       = '0;
        b       = '0;
        flush   = 1'b0;
    endtask

    task automatic drive(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y);
        valid   = 1'b1;
        aluctrl = code;
        a       = x;
        b       = y;
    endtask

    // Issues one op, counts stalled cycles (bounded), notes done, then steps through the commit edge.
    task automatic run_op(input logic [4:0] code, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int n_stall, output logic done_seen);
        drive(code, x, y);
        #1;
        n_stall = 0;
        while (stall === 1'b1 && n_stall < 50) begin
            n_stall++;
            step();
            idle_inputs();
            #1;
        end
        done_seen = done;
        step();
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL reset_hi: got %h want %h", hi, 32'h0); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL reset_lo: got %h want %h", lo, 32'h0); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall: got %b want 0", stall); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_multu();
        int n;
        logic d;
        run_op(MULTU_CONTROL, 32'hFFFFFFFF, 32'hFFFFFFFF, n, d);
        total++; if (n != 1) begin bad++; $display("FAIL multu_stall_cycles: got %0d want 1", n); end
        total++; if (d !== 1'b1) begin bad++; $display("FAIL multu_done: got %b want 1", d); end
        total++; if (hi !== 32'hFFFFFFFE) begin bad++; $display("FAIL multu_hi: got %h want %h", hi, 32'hFFFFFFFE); end
        total++; if (lo !== 32'h00000001) begin bad++; $display("FAIL multu_lo: got %h want %h", lo, 32'h00000001); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL multu_done_after: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int n;
        logic d;
        run_op(MULT_CONTROL, 32'hFFFFFFFD, 32'h7, n, d);
        total++; if (n != 1) begin bad++; $display("FAIL mult_stall_cycles: got %0d want 1", n); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL mult_hi: got %h want %h", hi, 32'hFFFFFFFF); end
        total++; if (lo !== 32'hFFFFFFEB) begin bad++; $display("FAIL mult_lo: got %h want %h", lo, 32'hFFFFFFEB); end
    endtask

    task automatic test_div();
        int n;
        logic d;
        run_op(DIV_CONTROL, 32'hFFFFFFF9, 32'h2, n, d);
        total++; if (n != 33) begin bad++; $display("FAIL div_stall_cycles: got %0d want 33", n); end
        total++; if (d !== 1'b1) begin bad++; $display("FAIL div_done: got %b want 1", d); end
        total++; if (lo !== 32'hFFFFFFFD) begin bad++; $display("FAIL div_lo: got %h want %h", lo, 32'hFFFFFFFD); end
        total++; if (hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL div_hi: got %h want %h", hi, 32'hFFFFFFFF); end
    endtask

    task automatic test_div_boundaries();
        int n;
        logic d;
        run_op(DIVU_CONTROL, 32'd100, 32'd0, n, d);
        total++; if (lo !== 32'hFFFFFFFF) begin bad++; $display("FAIL divu_zero_lo: got %h want %h", lo, 32'hFFFFFFFF); end
        total++; if (hi !== 32'd100) begin bad++; $display("FAIL divu_zero_hi: got %h want %h", hi, 32'd100); end
        run_op(DIV_CONTROL, 32'h80000000, 32'hFFFFFFFF, n, d);
        total++; if (lo !== 32'h80000000) begin bad++; $display("FAIL div_ovf_lo: got %h want %h", lo, 32'h80000000); end
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL div_ovf_hi: got %h want %h", hi, 32'h0); end
        run_op(DIVU_CONTROL, 32'hFFFFFFF9, 32'h2, n, d);
        total++; if (lo !== 32'h7FFFFFFC) begin bad++; $display("FAIL divu_big_lo: got %h want %h", lo, 32'h7FFFFFFC); end
        total++; if (hi !== 32'h1) begin bad++; $display("FAIL divu_big_hi: got %h want %h", hi, 32'h1); end
    endtask

    task automatic test_mt_back_to_back();
        drive(MTHI_CONTROL, 32'hDEADBEEF, 32'h0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mthi_stall: got %b want 0", stall); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL mthi_done: got %b want 0", done); end
        step();
        drive(MTLO_CONTROL, 32'h12345678, 32'h0);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL mtlo_stall: got %b want 0", stall); end
        total++; if (hi !== 32'hDEADBEEF) begin bad++; $display("FAIL mthi_hi: got %h want %h", hi, 32'hDEADBEEF); end
        step();
        idle_inputs();
        #1;
        total++; if (hi !== 32'hDEADBEEF) begin bad++; $display("FAIL mt_hi: got %h want %h", hi, 32'hDEADBEEF); end
        total++; if (lo !== 32'h12345678) begin bad++; $display("FAIL mt_lo: got %h want %h", lo, 32'h12345678); end
    endtask

    task automatic test_busy_ignore();
        int edges;
        drive(DIV_CONTROL, 32'd100, 32'd7);
        #1;
        step();
        idle_inputs();
        edges = 1;
        repeat (5) begin step(); edges++; end
        drive(MULT_CONTROL, 32'd3, 32'd3);
        #1;
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL busy_stall: got %b want 1", stall); end
        repeat (3) begin step(); edges++; end
        idle_inputs();
        #1;
        while (done !== 1'b1 && edges < 60) begin step(); edges++; end
        total++; if (edges != 33) begin bad++; $display("FAIL busy_done_edge: got %0d want 33", edges); end
        step();
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL busy_lo: got %h want %h", lo, 32'd14); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL busy_hi: got %h want %h", hi, 32'd2); end
    endtask

    task automatic test_flush_accept();
        drive(MULT_CONTROL, 32'd5, 32'd5);
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_accept_stall: got %b want 0", stall); end
        step();
        idle_inputs();
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_accept_done: got %b want 0", done); end
        step();
        total++; if (lo !== 32'd14) begin bad++; $display("FAIL flush_accept_lo: got %h want %h", lo, 32'd14); end
    endtask

    task automatic test_other_code();
        drive(5'b00010, 32'hFFFFFFFF, 32'hFFFFFFFF);
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL other_stall: got %b want 0", stall); end
        step();
        idle_inputs();
        #1;
        total++; if (done !== 1'b0) begin bad++; $display("FAIL other_done: got %b want 0", done); end
        total++; if (hi !== 32'd2) begin bad++; $display("FAIL other_hi: got %h want %h", hi, 32'd2); end
    endtask

    task automatic set_hilo_11_22();
        drive(MTHI_CONTROL, 32'h11, 32'h0);
        step();
        drive(MTLO_CONTROL, 32'h22, 32'h0);
        step();
        idle_inputs();
    endtask

    task automatic test_flush_div();
        int n;
        logic d;
        set_hilo_11_22();
        drive(DIV_CONTROL, 32'd50, 32'd7);
        #1;
        step();
        idle_inputs();
        repeat (10) step();
        flush = 1'b1;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_stall: got %b want 0", stall); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL flush_done: got %b want 0", done); end
        step();
        flush = 1'b0;
        #1;
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL flush_after_stall: got %b want 0", stall); end
        total++; if (hi !== 32'h11) begin bad++; $display("FAIL flush_hi: got %h want %h", hi, 32'h11); end
        total++; if (lo !== 32'h22) begin bad++; $display("FAIL flush_lo: got %h want %h", lo, 32'h22); end
        repeat (3) step();
        total++; if (lo !== 32'h22) begin bad++; $display("FAIL flush_no_late_commit: got %h want %h", lo, 32'h22); end
        run_op(MULTU_CONTROL, 32'd2, 32'd3, n, d);
        total++; if (n != 1) begin bad++; $display("FAIL flush_idle_mul_stall: got %0d want 1", n); end
        total++; if (lo !== 32'd6) begin bad++; $display("FAIL flush_idle_mul_lo: got %h want %h", lo, 32'd6); end
    endtask

    task automatic test_reset_mid_div();
        set_hilo_11_22();
        drive(DIV_CONTROL, 32'd50, 32'd7);
        #1;
        step();
        idle_inputs();
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        total++; if (hi !== 32'h0) begin bad++; $display("FAIL rst_mid_hi: got %h want %h", hi, 32'h0); end
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_mid_lo: got %h want %h", lo, 32'h0); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rst_mid_stall: got %b want 0", stall); end
        repeat (30) step();
        total++; if (lo !== 32'h0) begin bad++; $display("FAIL rst_mid_no_commit: got %h want %h", lo, 32'h0); end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_boundaries();
        test_mt_back_to_back();
        test_busy_ignore();
        test_flush_accept();
        test_other_code();
        test_flush_div();
        test_reset_mid_div();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multi-cycle multiply/divide unit in the EX stage, consuming the 5-bit ALU control code produced by the ALU decoder alongside the main ALU.
- Owns the architectural HI/LO registers and executes MULT/MULTU (2-cycle) and DIV/DIVU (34-cycle radix-2 restoring).
- Services MTHI/MTLO writes.
- Raises a stall to freeze IF/ID/EX while busy.

Parameters:
- WIDTH, 32, operand/HI/LO width.
- DIV_ITERS, 32, divider iterations; must equal WIDTH.

Ports:
- clk  in  1  rising-edge clock. Reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- valid  in  1  EX holds a live instruction this cycle.
- aluctrl  in  5  ALU control code from the decoder.
- a  in  WIDTH  rs operand (dividend/multiplicand, or MTHI/MTLO source).
- b  in  WIDTH  rt operand.
- flush  in  1  pipeline flush (exception/branch kill).
- stall  out  1  freeze upstream stages.
- done  out  1  result commits at the next edge.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset: state=IDLE, hi=0, lo=0, stall=0, done=0, iteration counter=0. Reset takes effect mid-operation and discards any partial result.
- Accept: only when valid && state==IDLE && !flush.
  - MULT/MULTU/DIV/DIVU operands latch on that edge.
  - In the accept cycle, stall=1 combinationally.
- States: IDLE, MUL, DIV, FIX.
  - IDLE→MUL on accept of a MULT/MULTU. MUL computes the 64-bit product (signed or unsigned per code) from latched operands. In MUL: done=1, stall=0. At the edge: {hi,lo}=product, →IDLE.
  - IDLE→DIV on accept of a DIV/DIVU. At entry: latch |a| and |b| (raw values for DIVU), store sign flags, clear remainder, set counter=0.
  - DIV runs one restoring step per cycle: shift the {rem,quo} pair left by 1, trial-subtract the divisor, set the quotient bit if the result is non-negative. After step counter==DIV_ITERS-1, →FIX. stall=1 throughout DIV.
  - FIX: for DIV, negate the quotient if the operand signs differ and give the remainder the sign of the dividend. done=1, stall=0. At the edge: lo=quotient, hi=remainder, →IDLE.
- Latency: MULT stalls 1 cycle (2 cycles occupied). DIV stalls 33 cycles (34 cycles occupied).
- MTHI/MTLO: accepted only in IDLE with valid; write a to hi/lo at the edge; no stall, done=0.
  - When state!=IDLE, the pipeline is stalled and no new code is accepted. Any code presented while busy is ignored.
- Divide by zero (fixed result, no trap): DIVU gives lo=0xFFFFFFFF, hi=a. DIV applies the same rule on magnitudes, then the FIX sign rules.
- Overflow: 0x80000000 / 0xFFFFFFFF (signed) gives lo=0x80000000, hi=0.
- flush: in any busy state, →IDLE at the next edge with hi/lo unchanged. stall=0 and done=0 in the flush cycle. A flush in the accept cycle suppresses the accept.
- All other aluctrl codes: no effect, stall=0.
- hi/lo change only on a committing edge (MUL/FIX exit or MTHI/MTLO).

Decomposition:
- Shared defines header gains the 5-bit codes MULT_CONTROL=5'b10000, MULTU_CONTROL=5'b10001, DIV_CONTROL=5'b10010, DIVU_CONTROL=5'b10011, MTHI_CONTROL=5'b10100, MTLO_CONTROL=5'b10101.
- State encodings stay local to the module.
- One sub-module: div_radix2. It holds the iterative unsigned restoring core (start, dividend, divisor, busy, quotient, remainder, abort). Sign pre/post-processing and HI/LO stay in mdu_hilo.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> stall=1 for 1 cycle, done next cycle; then hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=0xFFFFFFFD(-3) b=7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB(-21).
- DIV a=0xFFFFFFF9(-7) b=2 -> stall high exactly 33 cycles, done in cycle 34; then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100 b=0 -> lo=0xFFFFFFFF, hi=100. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIV 50/7 with flush at iteration 10 (prior hi=0x11, lo=0x22) -> next cycle state IDLE, stall=0, hi=0x11, lo=0x22 unchanged. Repeat with rst instead -> hi=lo=0.
- MTHI a=0xDEADBEEF then MTLO a=0x12345678 back-to-back -> no stall; hi=0xDEADBEEF, lo=0x12345678. A MULT code presented while DIV is busy is ignored.
